// File: rtl/soc_io_responder.sv
// Memory-mapped DE10-Lite board IO responder: LEDR, six 7-segment digits, SW and KEY.
// Single-outstanding valid/ready request/response; SW/KEY are synchronised and debounced.
module soc_io_responder #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ADDR_W          = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    input  logic [9:0]        sw_in,
    input  logic [1:0]        key_in,
    output logic [9:0]        ledr_out,
    output logic [47:0]       hex_out
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [ADDR_W-1:0] A_LEDR   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_DIGITS = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_HEXCTL = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_SW     = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_KEY    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_KEYEVT = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] A_CYCLES = ADDR_W'(6);

    logic          r_resp_valid;
    logic [31:0]   r_resp_rdata;
    logic [9:0]    r_ledr;
    logic [23:0]   r_digits;
    logic [5:0]    r_blank;
    logic [5:0]    r_dp;
    logic [1:0]    r_keyevt;
    logic [31:0]   r_cycles;
    // Bits [11:10] carry KEY already inverted to pressed=1, [9:0] carry SW.
    logic [11:0]   r_sync1;
    logic [11:0]   r_sync2;
    logic [11:0]   r_in_db;
    logic [CW-1:0] r_db_cnt [12];

    logic [11:0]   w_db_nxt;
    logic [CW-1:0] w_db_cnt_nxt [12];
    logic [1:0]    w_key_rise;
    logic [1:0]    w_evt_clr;
    logic          w_accept;
    logic          w_wr;
    logic [31:0]   w_rdata;
    logic [47:0]   w_hex;
    logic          w_unused_wdata;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            4'hF:    s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign w_accept       = req_valid & ~r_resp_valid;
    assign w_wr           = w_accept & req_write;
    assign w_unused_wdata = ^req_wdata[31:24];

    assign req_ready  = ~r_resp_valid;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign ledr_out   = r_ledr;
    assign hex_out    = w_hex;

    // Debounce next-state: a bit flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        w_db_nxt = r_in_db;
        for (int i = 0; i < 12; i++) begin
            w_db_cnt_nxt[i] = '0;
            if (r_sync2[i] != r_in_db[i]) begin
                if (r_db_cnt[i] == DB_LAST) begin
                    w_db_nxt[i] = r_sync2[i];
                end else begin
                    w_db_cnt_nxt[i] = r_db_cnt[i] + {{(CW-1){1'b0}}, 1'b1};
                end
            end else begin
                w_db_cnt_nxt[i] = '0;
            end
        end
        w_key_rise = w_db_nxt[11:10] & ~r_in_db[11:10];
    end

    // W1C mask for the key event register.
    always_comb begin
        if (w_wr && (req_addr == A_KEYEVT)) begin
            w_evt_clr = req_wdata[1:0];
        end else begin
            w_evt_clr = 2'b00;
        end
    end

    // Load data multiplexer over the register window.
    always_comb begin
        w_rdata = 32'd0;
        case (req_addr)
            A_LEDR:   w_rdata = {22'd0, r_ledr};
            A_DIGITS: w_rdata = {8'd0, r_digits};
            A_HEXCTL: w_rdata = {20'd0, r_dp, r_blank};
            A_SW:     w_rdata = {22'd0, r_in_db[9:0]};
            A_KEY:    w_rdata = {30'd0, r_in_db[11:10]};
            A_KEYEVT: w_rdata = {30'd0, r_keyevt};
            A_CYCLES: w_rdata = r_cycles;
            default:  w_rdata = 32'd0;
        endcase
    end

    // Seven-segment decode; a blanked digit also suppresses its dp.
    always_comb begin
        w_hex = 48'd0;
        for (int n = 0; n < 6; n++) begin
            if (r_blank[n]) begin
                w_hex[8*n +: 8] = 8'hFF;
            end else begin
                w_hex[8*n +: 8] = {~r_dp[n], seg7(r_digits[4*n +: 4])};
            end
        end
    end

    // Request/response handshake; reset drops any pending response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
        end else if (w_accept) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= req_write ? 32'd0 : w_rdata;
        end else if (resp_ready) begin
            r_resp_valid <= 1'b0;
        end else begin
            r_resp_valid <= r_resp_valid;
        end
    end

    // Writable control registers and the free-running cycle counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ledr   <= 10'd0;
            r_digits <= 24'd0;
            r_blank  <= 6'h3F;
            r_dp     <= 6'd0;
            r_cycles <= 32'd0;
        end else begin
            r_cycles <= r_cycles + 32'd1;
            if (w_wr && (req_addr == A_LEDR)) begin
                r_ledr <= req_wdata[9:0];
            end
            if (w_wr && (req_addr == A_DIGITS)) begin
                r_digits <= req_wdata[23:0];
            end
            if (w_wr && (req_addr == A_HEXCTL)) begin
                r_blank <= req_wdata[5:0];
                r_dp    <= req_wdata[11:6];
            end
        end
    end

    // Input synchroniser, debouncer and sticky key events (a set beats a same-cycle clear).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1  <= 12'd0;
            r_sync2  <= 12'd0;
            r_in_db  <= 12'd0;
            r_keyevt <= 2'b00;
            for (int i = 0; i < 12; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1  <= {~key_in, sw_in};
            r_sync2  <= r_sync1;
            r_in_db  <= w_db_nxt;
            r_keyevt <= (r_keyevt & ~w_evt_clr) | w_key_rise;
            for (int i = 0; i < 12; i++) begin
                r_db_cnt[i] <= w_db_cnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_soc_io_responder.sv
// Scoreboard bench for soc_io_responder: expected load data queued at acceptance,
// compared when the response handshake completes.
module tb_soc_io_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [9:0]  sw_in;
    logic [1:0]  key_in;
    logic [9:0]  ledr_out;
    logic [47:0] hex_out;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q [$];
    logic [31:0] tb_cyc;

    always #5 clk = ~clk;

    soc_io_responder #(.DEBOUNCE_CYCLES(16), .ADDR_W(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .sw_in(sw_in), .key_in(key_in), .ledr_out(ledr_out), .hex_out(hex_out)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference cycle count: value of the DUT counter just before each edge.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) tb_cyc <= 32'd0;
        else          tb_cyc <= tb_cyc + 32'd1;
    end

    // Response monitor: pop and compare when the handshake completes.
    always @(negedge clk) begin
        logic [31:0] e;
        if (reset_n && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_resp", {63'd0, resp_valid}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("resp_rdata", {32'd0, resp_rdata}, {32'd0, e});
            end
        end
    end

    task automatic bus(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp, input bit use_cyc);
        bit done = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin
                exp_q.push_back(use_cyc ? tb_cyc : exp);
                done = 1'b1;
            end
        end
        if (!done) check_val("accept_timeout", {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        check_val("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 4'd0;
        req_wdata = 32'd0; resp_ready = 1'b1; sw_in = 10'd0; key_in = 2'b11;
        #12;
        check_val("rst_hex", {16'd0, hex_out}, {16'd0, 48'hFFFF_FFFF_FFFF});
        check_val("rst_ledr", {54'd0, ledr_out}, 64'd0);
        check_val("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check_val("rst_req_ready", {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1; reset_n = 1'b1;

        // LEDR store and load
        bus(1'b1, 4'd0, 32'hFFFF_F2A5, 32'd0, 1'b0);
        check_val("ledr_out", {54'd0, ledr_out}, {54'd0, 10'h2A5});
        bus(1'b0, 4'd0, 32'd0, 32'h0000_02A5, 1'b0);

        // Digits and HEX control
        bus(1'b1, 4'd1, 32'h0000_18AF, 32'd0, 1'b0);
        check_val("hex_blanked", {16'd0, hex_out}, {16'd0, 48'hFFFF_FFFF_FFFF});
        bus(1'b1, 4'd2, 32'h0000_0830, 32'd0, 1'b0);
        check_val("hex_digits", {16'd0, hex_out}, {16'd0, 48'hFFFF_F980_888E});
        bus(1'b1, 4'd2, 32'h0000_0040, 32'd0, 1'b0);
        check_val("hex_dp0", {16'd0, hex_out}, {16'd0, 48'hC0C0_F980_880E});
        bus(1'b0, 4'd1, 32'd0, 32'h0000_18AF, 1'b0);
        bus(1'b0, 4'd2, 32'd0, 32'h0000_0040, 1'b0);

        // Unmapped address and read-only register writes
        bus(1'b1, 4'd9, 32'hFFFF_FFFF, 32'd0, 1'b0);
        bus(1'b0, 4'd9, 32'd0, 32'd0, 1'b0);
        bus(1'b1, 4'd6, 32'h1234_5678, 32'd0, 1'b0);
        bus(1'b0, 4'd6, 32'd0, 32'd0, 1'b1);
        bus(1'b0, 4'd0, 32'd0, 32'h0000_02A5, 1'b0);
        drain();

        // Backpressure: response held, second request stalls
        resp_ready = 1'b0;
        bus(1'b0, 4'd0, 32'd0, 32'h0000_02A5, 1'b0);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("bp_resp_valid", {63'd0, resp_valid}, 64'd1);
            check_val("bp_resp_rdata", {32'd0, resp_rdata}, 64'h2A5);
            check_val("bp_req_ready", {63'd0, req_ready}, 64'd0);
        end
        @(posedge clk); #1; resp_ready = 1'b1;
        @(negedge clk);
        check_val("bp_req_ready_hs", {63'd0, req_ready}, 64'd0);
        @(negedge clk);
        check_val("bp_req_ready_back", {63'd0, req_ready}, 64'd1);
        exp_q.push_back(32'd0);
        @(posedge clk); #1; req_valid = 1'b0;
        drain();

        // Debounce: glitches rejected, stable level accepted
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1; sw_in[3] = ~sw_in[3];
        end
        sw_in = 10'd0;
        repeat (30) @(posedge clk);
        bus(1'b0, 4'd3, 32'd0, 32'd0, 1'b0);
        sw_in = 10'h008;
        repeat (8) @(posedge clk);
        bus(1'b0, 4'd3, 32'd0, 32'd0, 1'b0);
        repeat (20) @(posedge clk);
        bus(1'b0, 4'd3, 32'd0, 32'h0000_0008, 1'b0);

        // Key press, sticky event
        @(posedge clk); #1; key_in = 2'b01;
        repeat (25) @(posedge clk);
        bus(1'b0, 4'd4, 32'd0, 32'h0000_0002, 1'b0);
        key_in = 2'b11;
        repeat (25) @(posedge clk);
        bus(1'b0, 4'd5, 32'd0, 32'h0000_0002, 1'b0);
        bus(1'b0, 4'd4, 32'd0, 32'd0, 1'b0);
        drain();

        // W1C landing on the same edge as a new KEY0 debounced press
        @(posedge clk); #1; key_in = 2'b10;
        repeat (17) @(posedge clk);
        #1; req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd5; req_wdata = 32'h3;
        @(negedge clk);
        check_val("w1c_req_ready", {63'd0, req_ready}, 64'd1);
        exp_q.push_back(32'd0);
        @(posedge clk); #1; req_valid = 1'b0;
        bus(1'b0, 4'd5, 32'd0, 32'h0000_0001, 1'b0);
        key_in = 2'b11;
        drain();

        // Reset with a response pending
        resp_ready = 1'b0;
        bus(1'b1, 4'd0, 32'h0000_03FF, 32'd0, 1'b0);
        check_val("ledr_pre_rst", {54'd0, ledr_out}, {54'd0, 10'h3FF});
        #2; reset_n = 1'b0; #1;
        exp_q.delete();
        check_val("mid_rst_hex", {16'd0, hex_out}, {16'd0, 48'hFFFF_FFFF_FFFF});
        check_val("mid_rst_ledr", {54'd0, ledr_out}, 64'd0);
        check_val("mid_rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check_val("mid_rst_req_ready", {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1; reset_n = 1'b1; resp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("post_rst_no_resp", {63'd0, resp_valid}, 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
